// File: rtl/axis_flit_injector_if.sv
// AXI-Stream beat input, flit send output and credit return for the flit injector.
// Latency: none. This is a bundle of wires.
// Backpressure: axis_tready stalls the AXIS source; credit_in/credits_avail carry the downstream buffer state.
//
// Modports:
//   slave  - the injector. It consumes AXIS beats and credits and drives flits and status.
//   master - the environment. It drives AXIS beats and credits and observes flits and status.
interface axis_flit_injector_if #(
    parameter int TDATA_WIDTH          = 128,
    parameter int TID_WIDTH            = 2,
    parameter int TDEST_WIDTH          = 2,
    parameter int SERIALIZATION_FACTOR = 1,
    parameter int FLIT_BUFFER_DEPTH    = 4,
    parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
    parameter int DEST_WIDTH           = TID_WIDTH + TDEST_WIDTH,
    parameter int CREDIT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1)
);
    logic                    axis_tvalid;
    logic                    axis_tready;
    logic [TDATA_WIDTH-1:0]  axis_tdata;
    logic                    axis_tlast;
    logic [TID_WIDTH-1:0]    axis_tid;
    logic [TDEST_WIDTH-1:0]  axis_tdest;

    logic [FLIT_WIDTH-1:0]   data_out;
    logic [DEST_WIDTH-1:0]   dest_out;
    logic                    is_tail_out;
    logic                    send_out;

    logic                    credit_in;
    logic [CREDIT_WIDTH-1:0] credits_avail;
    logic                    credit_overflow;

    modport slave (
        input  axis_tvalid, axis_tdata, axis_tlast, axis_tid, axis_tdest, credit_in,
        output axis_tready, data_out, dest_out, is_tail_out, send_out,
               credits_avail, credit_overflow
    );

    modport master (
        output axis_tvalid, axis_tdata, axis_tlast, axis_tid, axis_tdest, credit_in,
        input  axis_tready, data_out, dest_out, is_tail_out, send_out,
               credits_avail, credit_overflow
    );
endinterface

// File: rtl/axis_flit_injector.sv
// Splits each AXIS beat into SERIALIZATION_FACTOR flits, lowest slice first, and issues them under send/credit flow control.
// Latency: a beat accepted at edge k shows flit 0 on send_out in cycle k, provided a credit is held. After that it issues one flit per cycle.
// Backpressure: axis_tready drops while a beat is still being serialised. Flits stall while the credit count is zero.
//
// Ports:
//   clk_noc, rst_n - NoC clock (rising edge) and asynchronous active-low reset
//   bus (slave)    - AXIS beat in (tvalid/tready/tdata/tlast/tid/tdest), flit out
//                    (data_out/dest_out/is_tail_out/send_out), credit_in return,
//                    credits_avail count and sticky credit_overflow flag
module axis_flit_injector #(
    parameter int TDATA_WIDTH          = 128,
    parameter int TID_WIDTH            = 2,
    parameter int TDEST_WIDTH          = 2,
    parameter int SERIALIZATION_FACTOR = 1,
    parameter int FLIT_BUFFER_DEPTH    = 4,
    parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
    parameter int DEST_WIDTH           = TID_WIDTH + TDEST_WIDTH,
    parameter int CREDIT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                  clk_noc,
    input  logic                  rst_n,
    axis_flit_injector_if.slave   bus
);
    localparam int IDX_WIDTH = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
    localparam logic [IDX_WIDTH-1:0]    IDX_LAST = IDX_WIDTH'(SERIALIZATION_FACTOR - 1);
    localparam logic [CREDIT_WIDTH-1:0] CRED_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

    // Beat register
    logic                    beat_vld;
    logic [TDATA_WIDTH-1:0]  beat_dat;
    logic                    beat_last;
    logic [TID_WIDTH-1:0]    beat_tid;
    logic [TDEST_WIDTH-1:0]  beat_tdest;
    logic [IDX_WIDTH-1:0]    idx;

    // Credit state
    logic [CREDIT_WIDTH-1:0] cred;
    logic [CREDIT_WIDTH-1:0] cred_nxt;
    logic                    ovf;
    logic                    ovf_set;

    logic                    fire;
    logic                    last_flit;
    logic                    tready;
    logic                    accept;

    assign fire      = beat_vld & (cred != '0);
    assign last_flit = fire & (idx == IDX_LAST);
    // The last flit leaving frees the register for a new beat on the same edge.
    // This gives back-to-back beats.
    assign tready    = ~beat_vld | last_flit;
    assign accept    = bus.axis_tvalid & tready;

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            beat_vld   <= 1'b0;
            beat_dat   <= '0;
            beat_last  <= 1'b0;
            beat_tid   <= '0;
            beat_tdest <= '0;
            idx        <= '0;
        end else if (accept) begin
            // Loading takes priority over emptying when both happen together.
            beat_vld   <= 1'b1;
            beat_dat   <= bus.axis_tdata;
            beat_last  <= bus.axis_tlast;
            beat_tid   <= bus.axis_tid;
            beat_tdest <= bus.axis_tdest;
            idx        <= '0;
        end else if (last_flit) begin
            beat_vld   <= 1'b0;
            idx        <= '0;
        end else if (fire) begin
            idx        <= idx + IDX_WIDTH'(1);
        end
    end

    // Credits: a returned credit with no flit going out raises the count.
    // If the count is already full, that credit is dropped (the counter saturates) and the error is flagged.
    always_comb begin
        cred_nxt = cred;
        ovf_set  = 1'b0;
        if (fire && !bus.credit_in) begin
            cred_nxt = cred - CREDIT_WIDTH'(1);
        end else if (!fire && bus.credit_in) begin
            if (cred == CRED_MAX) begin
                ovf_set = 1'b1;
            end else begin
                cred_nxt = cred + CREDIT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            cred <= CRED_MAX;
            ovf  <= 1'b0;
        end else begin
            cred <= cred_nxt;
            ovf  <= ovf | ovf_set;
        end
    end

    generate
        if (SERIALIZATION_FACTOR == 1) begin : g_flat
            assign bus.data_out = beat_dat;
        end else begin : g_slice
            logic [SERIALIZATION_FACTOR-1:0][FLIT_WIDTH-1:0] slices;
            assign slices       = beat_dat;
            assign bus.data_out = slices[idx];
        end
    endgenerate

    assign bus.dest_out        = {beat_tid, beat_tdest};
    assign bus.is_tail_out     = beat_last & (idx == IDX_LAST);
    assign bus.send_out        = fire;
    assign bus.axis_tready     = tready;
    assign bus.credits_avail   = cred;
    assign bus.credit_overflow = ovf;
endmodule

// File: tb/tb_axis_flit_injector.sv
// Directed checks plus a random stress run on two injector instances.
// u_dut4 serialises each beat into 4 flits; u_dut1 sends one flit per beat. Both have 4 credits.
// Inputs are driven and outputs sampled on the falling edge of clk_noc.
module tb_axis_flit_injector;
    localparam int NB = 1000;

    logic clk_noc = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_noc = ~clk_noc;

    axis_flit_injector_if #(.TDATA_WIDTH(128), .SERIALIZATION_FACTOR(4), .FLIT_BUFFER_DEPTH(4)) if4 ();
    axis_flit_injector_if #(.TDATA_WIDTH(128), .SERIALIZATION_FACTOR(1), .FLIT_BUFFER_DEPTH(4)) if1 ();

    axis_flit_injector #(.TDATA_WIDTH(128), .SERIALIZATION_FACTOR(4), .FLIT_BUFFER_DEPTH(4)) u_dut4 (
        .clk_noc (clk_noc),
        .rst_n   (rst_n),
        .bus     (if4)
    );

    axis_flit_injector #(.TDATA_WIDTH(128), .SERIALIZATION_FACTOR(1), .FLIT_BUFFER_DEPTH(4)) u_dut1 (
        .clk_noc (clk_noc),
        .rst_n   (rst_n),
        .bus     (if1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        if4.axis_tvalid = 1'b0; if4.axis_tdata = '0; if4.axis_tlast = 1'b0;
        if4.axis_tid = '0; if4.axis_tdest = '0; if4.credit_in = 1'b0;
        if1.axis_tvalid = 1'b0; if1.axis_tdata = '0; if1.axis_tlast = 1'b0;
        if1.axis_tid = '0; if1.axis_tdest = '0; if1.credit_in = 1'b0;
        repeat (2) @(negedge clk_noc);
        rst_n = 1'b1;
    endtask

    // Scoreboard for the stress run
    logic [31:0] exp_q[$];
    logic        tail_q[$];

    initial begin
        int          beat;
        int          sends;
        logic        acc;
        logic [31:0] cur [4];
        logic        cur_last;
        logic        have;
        logic        cr;
        int          occ, cyc, beats_in, data_errs, range_errs, outst_errs;
        logic [31:0] e;
        logic        et;

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_send",   if4.send_out, 0);
        chk("rst_data",   if4.data_out, 0);
        chk("rst_dest",   if4.dest_out, 0);
        chk("rst_tail",   if4.is_tail_out, 0);
        chk("rst_tready", if4.axis_tready, 1);
        chk("rst_cred",   if4.credits_avail, 4);
        chk("rst_ovf",    if4.credit_overflow, 0);
        chk("rst1_cred",  if1.credits_avail, 4);

        // ---------------- SF=4 single beat ----------------
        if4.axis_tvalid = 1'b1;
        if4.axis_tdata  = {32'd3, 32'd2, 32'd1, 32'd0};
        if4.axis_tlast  = 1'b1;
        if4.axis_tid    = 2'd1;
        if4.axis_tdest  = 2'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_noc);
            if4.axis_tvalid = 1'b0;
            chk("ser_send",   if4.send_out, 1);
            chk("ser_data",   if4.data_out, i);
            chk("ser_dest",   if4.dest_out, 4'b0110);
            chk("ser_tail",   if4.is_tail_out, (i == 3));
            chk("ser_tready", if4.axis_tready, (i == 3));
        end
        @(negedge clk_noc);
        chk("ser_idle_send", if4.send_out, 0);
        chk("ser_cred0",     if4.credits_avail, 0);
        if4.credit_in = 1'b1;
        repeat (4) @(negedge clk_noc);
        if4.credit_in = 1'b0;
        chk("ser_cred_back", if4.credits_avail, 4);
        chk("ser_no_ovf",    if4.credit_overflow, 0);

        // ---------------- SF=1 credit exhaustion ----------------
        do_reset();
        if1.axis_tvalid = 1'b1;
        if1.axis_tdata  = '0;
        if1.axis_tlast  = 1'b1;
        beat  = 0;
        sends = 0;
        acc   = if1.axis_tready;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk_noc);
            if (acc) begin
                beat++;
                if1.axis_tdata = 128'(beat);
            end
            if (c <= 4) begin
                chk("cr_send", if1.send_out, 1);
                chk("cr_data", if1.data_out, c - 1);
            end else begin
                chk("cr_stall_send",   if1.send_out, 0);
                chk("cr_stall_cred",   if1.credits_avail, 0);
                chk("cr_stall_tready", if1.axis_tready, 0);
            end
            sends += int'(if1.send_out);
            acc = if1.axis_tvalid & if1.axis_tready;
        end
        chk("cr_flit_count", sends, 4);
        if1.credit_in = 1'b1;
        @(negedge clk_noc);
        if1.credit_in = 1'b0;
        chk("cr_hold_send", if1.send_out, 1);
        chk("cr_hold_data", if1.data_out, 4);
        chk("cr_hold_cred", if1.credits_avail, 1);
        @(negedge clk_noc);
        chk("cr_after_send", if1.send_out, 0);
        chk("cr_after_cred", if1.credits_avail, 0);

        // ---------------- SF=1 steady flow, credit returned per flit ----------------
        do_reset();
        if1.axis_tvalid = 1'b1;
        if1.axis_tdata  = '0;
        beat = 0;
        acc  = if1.axis_tready;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_noc);
            if (acc) begin
                beat++;
                if1.axis_tdata = 128'(beat);
            end
            chk("flow_send", if1.send_out, 1);
            chk("flow_data", if1.data_out, c - 1);
            chk("flow_cred", if1.credits_avail, 4);
            if1.credit_in = if1.send_out;
            acc = if1.axis_tvalid & if1.axis_tready;
        end

        // ---------------- overflow ----------------
        do_reset();
        if4.credit_in = 1'b1;
        @(negedge clk_noc);
        if4.credit_in = 1'b0;
        chk("ovf_cred", if4.credits_avail, 4);
        chk("ovf_set",  if4.credit_overflow, 1);
        repeat (5) @(negedge clk_noc);
        chk("ovf_sticky",      if4.credit_overflow, 1);
        chk("ovf_cred_sticky", if4.credits_avail, 4);
        do_reset();
        chk("ovf_cleared", if4.credit_overflow, 0);

        // ---------------- reset mid-packet ----------------
        if4.axis_tvalid = 1'b1;
        if4.axis_tdata  = {32'd13, 32'd12, 32'd11, 32'd10};
        if4.axis_tlast  = 1'b1;
        if4.axis_tid    = 2'd3;
        if4.axis_tdest  = 2'd1;
        @(negedge clk_noc);
        if4.axis_tvalid = 1'b0;
        chk("mid_f0", if4.data_out, 10);
        @(negedge clk_noc);
        chk("mid_f1", if4.data_out, 11);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_send",   if4.send_out, 0);
        chk("mid_rst_cred",   if4.credits_avail, 4);
        chk("mid_rst_tready", if4.axis_tready, 1);
        @(negedge clk_noc);
        rst_n = 1'b1;
        if4.axis_tvalid = 1'b1;
        if4.axis_tdata  = {32'd23, 32'd22, 32'd21, 32'd20};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_noc);
            if4.axis_tvalid = 1'b0;
            chk("mid_new_send", if4.send_out, 1);
            chk("mid_new_data", if4.data_out, 20 + i);
            chk("mid_new_tail", if4.is_tail_out, (i == 3));
        end

        // ---------------- random stress on SF=4 ----------------
        do_reset();
        occ = 0; cyc = 0; beats_in = 0; have = 1'b0;
        data_errs = 0; range_errs = 0; outst_errs = 0;
        cur_last = 1'b0;
        for (int j = 0; j < 4; j++) cur[j] = '0;
        while ((beats_in < NB || exp_q.size() != 0) && cyc < 40000) begin
            @(negedge clk_noc);
            cyc++;
            if (int'(if4.credits_avail) != 4 - occ) data_errs++;
            if (int'(if4.credits_avail) > 4) range_errs++;
            if (if4.send_out) begin
                if (exp_q.size() == 0) begin
                    data_errs++;
                end else begin
                    e  = exp_q.pop_front();
                    et = tail_q.pop_front();
                    if (if4.data_out !== e || if4.is_tail_out !== et) data_errs++;
                end
            end
            // The downstream buffer only returns a slot it actually holds.
            cr = (occ > 0) && ($urandom_range(0, 1) == 1);
            if4.credit_in = cr;
            occ = occ + int'(if4.send_out) - int'(cr);
            if (occ > 4) outst_errs++;
            if (!have && beats_in < NB) begin
                for (int j = 0; j < 4; j++) cur[j] = $urandom;
                cur_last         = 1'($urandom_range(0, 1));
                if4.axis_tdata   = {cur[3], cur[2], cur[1], cur[0]};
                if4.axis_tlast   = cur_last;
                if4.axis_tid     = 2'($urandom_range(0, 3));
                if4.axis_tdest   = 2'($urandom_range(0, 3));
                have = 1'b1;
            end
            if4.axis_tvalid = have && ($urandom_range(0, 3) != 0);
            if (if4.axis_tvalid && if4.axis_tready) begin
                for (int j = 0; j < 4; j++) begin
                    exp_q.push_back(cur[j]);
                    tail_q.push_back(cur_last && (j == 3));
                end
                have = 1'b0;
                beats_in++;
            end
        end
        if4.axis_tvalid = 1'b0;
        if4.credit_in   = 1'b0;
        chk("stress_done_in_time", (cyc < 40000), 1);
        chk("stress_beats",        beats_in, NB);
        chk("stress_flit_errs",    data_errs, 0);
        chk("stress_cred_range",   range_errs, 0);
        chk("stress_outstanding",  outst_errs, 0);
        chk("stress_no_ovf",       if4.credit_overflow, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
